// File: rtl/ham_15_11_enc_sched_if.sv
// Bus bundle for the shared (15,11) Hamming encoder scheduler: requester
// side, encoder side and downstream codeword handshake.
interface ham_15_11_enc_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = 2
);

  // Requester side: one valid/ready pair and one 11-bit word per requester
  logic [NUM_REQ-1:0]    req_valid;
  logic [11*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;

  // Shared combinational encoder: word out, codeword back
  logic [10:0]           enc_d;
  logic [14:0]           enc_c;

  // Downstream codeword handshake
  logic                  out_valid;
  logic [14:0]           out_code;
  logic [SRC_W-1:0]      out_src;
  logic                  out_ready;

  // Scheduler view
  modport master (
    input  req_valid,
    input  req_data,
    input  enc_c,
    input  out_ready,
    output req_ready,
    output enc_d,
    output out_valid,
    output out_code,
    output out_src
  );

  // Environment view (requesters, encoder and downstream sink together)
  modport slave (
    output req_valid,
    output req_data,
    output enc_c,
    output out_ready,
    input  req_ready,
    input  enc_d,
    input  out_valid,
    input  out_code,
    input  out_src
  );

endinterface

// File: rtl/ham_15_11_enc_sched.sv
// Round-robin scheduler in front of a single shared (15,11) Hamming encoder.
// One word is in flight at a time: grant in IDLE, encode in ENC, then the
// registered codeword waits in HOLD until downstream accepts it.
module ham_15_11_enc_sched #(
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  ham_15_11_enc_sched_if.master        bus,
  output logic                         busy,
  output logic [15:0]                  word_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [SRC_W-1:0]   last_grant;
  logic [10:0]        data_reg;
  logic [SRC_W-1:0]   src_reg;
  logic [14:0]        out_code_reg;
  logic [SRC_W-1:0]   out_src_reg;
  logic               out_valid_reg;
  logic [15:0]        word_cnt_reg;

  logic               grant_any;
  logic [SRC_W-1:0]   grant_idx;
  logic [SRC_W-1:0]   cand;
  logic [NUM_REQ-1:0] req_ready_c;
  logic [10:0]        req_word [NUM_REQ];

  // Slice the flat request bus into one word per requester so the granted
  // word can be picked with a plain array index
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_word[g] = bus.req_data[11*g +: 11];
  end

  // Round-robin search starting just after the last grant; candidates are
  // scanned from lowest to highest priority so the highest one wins last
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = SRC_W'((int'(last_grant) + k) % NUM_REQ);
      if (bus.req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Grant is offered only while idle, and only to a requester that is asking
  always_comb begin
    req_ready_c = '0;
    if (state == IDLE && grant_any) begin
      req_ready_c = NUM_REQ'(1) << grant_idx;
    end
  end

  // Next-state logic: one word walks IDLE -> ENC -> HOLD -> IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_any) begin
          state_nxt = ENC;
        end
      end
      ENC: begin
        state_nxt = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the granted word and remember who won; last_grant starts at the
  // top index so requester 0 is favoured right after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg   <= '0;
      src_reg    <= '0;
      last_grant <= SRC_W'(NUM_REQ - 1);
    end else if (state == IDLE && grant_any) begin
      data_reg   <= req_word[grant_idx];
      src_reg    <= grant_idx;
      last_grant <= grant_idx;
    end
  end

  // Register the encoder result and present it until downstream takes it;
  // out_code/out_src are untouched while stalled in HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_code_reg  <= '0;
      out_src_reg   <= '0;
      out_valid_reg <= 1'b0;
    end else if (state == ENC) begin
      out_code_reg  <= bus.enc_c;
      out_src_reg   <= src_reg;
      out_valid_reg <= 1'b1;
    end else if (state == HOLD && bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Count delivered codewords; wraps silently at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_reg <= '0;
    end else if (state == HOLD && bus.out_ready) begin
      word_cnt_reg <= word_cnt_reg + 16'd1;
    end
  end

  // The encoder always sees the latched word, never the raw request bus,
  // so it does not toggle with unselected requesters
  assign bus.enc_d     = data_reg;
  assign bus.req_ready = req_ready_c;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_code  = out_code_reg;
  assign bus.out_src   = out_src_reg;
  assign busy          = (state != IDLE);
  assign word_cnt      = word_cnt_reg;

endmodule

// File: tb/tb_ham_15_11_enc_sched.sv
// Self-checking bench for ham_15_11_enc_sched: known encoding vectors,
// backpressure, round-robin fairness, random traffic against a behavioural
// model, and asynchronous reset in the middle of a word.
module tb_ham_15_11_enc_sched;

  localparam int NUM_REQ = 4;
  localparam int SRC_W   = 2;

  logic        clk;
  logic        rst_n;
  logic        busy;
  logic [15:0] word_cnt;

  int checks;
  int errors;

  int          last_g;
  logic [15:0] exp_cnt;

  logic [10:0] word_q [NUM_REQ];

  typedef struct {
    int          src;
    logic [10:0] data;
    logic [14:0] code;
  } vec_t;

  vec_t vecs [4];

  ham_15_11_enc_sched_if #(.NUM_REQ(NUM_REQ), .SRC_W(SRC_W)) bus_if ();

  ham_15_11_enc_sched #(.NUM_REQ(NUM_REQ), .SRC_W(SRC_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_if),
    .busy     (busy),
    .word_cnt (word_cnt)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Requester words are kept per requester and packed onto the flat bus
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
    assign bus_if.req_data[11*g +: 11] = word_q[g];
  end

  // Textbook Hamming(15,11): codeword bit p-1 is position p; parity bits sit
  // at positions 1,2,4,8 and data fills the others in ascending order
  function automatic logic [14:0] ham_enc(input logic [10:0] d);
    logic [14:0] c;
    logic        par;
    int          di;
    c  = '0;
    di = 0;
    for (int pos = 1; pos <= 15; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = d[di];
        di++;
      end
    end
    for (int p = 0; p < 4; p++) begin
      par = 1'b0;
      for (int pos = 1; pos <= 15; pos++) begin
        if ((pos & (1 << p)) != 0) par = par ^ c[pos-1];
      end
      c[(1 << p) - 1] = par;
    end
    return c;
  endfunction

  // The shared encoder lives outside the scheduler
  assign bus_if.enc_c = ham_enc(bus_if.enc_d);

  // Round-robin reference: first asking requester after the last winner
  function automatic int rr_pick(input int last, input logic [NUM_REQ-1:0] v);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic rdy);
    bus_if.req_valid = valid;
    bus_if.out_ready = rdy;
  endtask

  // Push one word from a single requester through the scheduler; optionally
  // stall downstream and raise a second requester while stalled
  task automatic sendWord(input int src, input logic [10:0] data,
                          input logic [14:0] exp_code, input int stall, input int extra);
    int waited;
    word_q[src] = data;
    applyStimulus(NUM_REQ'(1) << src, (stall == 0));
    #1;
    waited = 0;
    while (bus_if.req_ready == '0 && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    checkOutput("grant", 32'(bus_if.req_ready), 32'(NUM_REQ'(1) << src));
    @(posedge clk);
    #1;
    applyStimulus('0, (stall == 0));
    last_g = src;
    @(negedge clk);
    #1;
    checkOutput("enc_d", 32'(bus_if.enc_d), 32'(data));
    checkOutput("busy_enc", 32'(busy), 32'd1);
    checkOutput("valid_enc", 32'(bus_if.out_valid), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("valid_hold", 32'(bus_if.out_valid), 32'd1);
    checkOutput("code", 32'(bus_if.out_code), 32'(exp_code));
    checkOutput("src", 32'(bus_if.out_src), 32'(src));
    for (int i = 0; i < stall; i++) begin
      if (extra >= 0 && i == 0) bus_if.req_valid = NUM_REQ'(1) << extra;
      @(negedge clk);
      #1;
      checkOutput("stall_valid", 32'(bus_if.out_valid), 32'd1);
      checkOutput("stall_code", 32'(bus_if.out_code), 32'(exp_code));
      checkOutput("stall_src", 32'(bus_if.out_src), 32'(src));
      checkOutput("stall_ready", 32'(bus_if.req_ready), 32'd0);
      checkOutput("stall_cnt", 32'(word_cnt), 32'(exp_cnt));
    end
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    #1;
    exp_cnt = exp_cnt + 16'd1;
    checkOutput("deliver_valid", 32'(bus_if.out_valid), 32'd0);
    checkOutput("deliver_cnt", 32'(word_cnt), 32'(exp_cnt));
    checkOutput("deliver_busy", 32'(busy), 32'd0);
  endtask

  // Cycle-level traffic against the model: requesters raise valid at random
  // (or all the time) and hold it until granted; downstream stalls at random
  task automatic runRandom(input int cycles, input bit all_valid);
    logic [NUM_REQ-1:0] pend;
    logic [10:0]        m_data;
    logic [14:0]        m_code;
    int                 m_src;
    int                 phase;
    int                 g;
    int                 n;
    bit                 drain;
    pend   = '0;
    phase  = 0;
    m_data = '0;
    m_code = '0;
    m_src  = 0;
    n      = 0;
    while ((n < cycles || phase != 0) && n < cycles + 10) begin
      drain = (n >= cycles);
      @(negedge clk);
      if (drain) begin
        pend = '0;
      end else begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!pend[i] && (all_valid || $urandom_range(0, 2) == 0)) begin
            pend[i]   = 1'b1;
            word_q[i] = 11'($urandom);
          end
        end
      end
      applyStimulus(pend, (all_valid || drain) ? 1'b1 : ($urandom_range(0, 3) != 0));
      #1;
      checkOutput("rnd_cnt", 32'(word_cnt), 32'(exp_cnt));
      case (phase)
        0: begin
          g = rr_pick(last_g, pend);
          checkOutput("rnd_valid_idle", 32'(bus_if.out_valid), 32'd0);
          if (g >= 0) begin
            checkOutput("rnd_grant", 32'(bus_if.req_ready), 32'(NUM_REQ'(1) << g));
            m_src   = g;
            m_data  = word_q[g];
            m_code  = ham_enc(m_data);
            pend[g] = 1'b0;
            last_g  = g;
            phase   = 1;
          end else begin
            checkOutput("rnd_nogrant", 32'(bus_if.req_ready), 32'd0);
          end
        end
        1: begin
          checkOutput("rnd_ready_enc", 32'(bus_if.req_ready), 32'd0);
          checkOutput("rnd_valid_enc", 32'(bus_if.out_valid), 32'd0);
          checkOutput("rnd_enc_d", 32'(bus_if.enc_d), 32'(m_data));
          phase = 2;
        end
        default: begin
          checkOutput("rnd_ready_hold", 32'(bus_if.req_ready), 32'd0);
          checkOutput("rnd_valid_hold", 32'(bus_if.out_valid), 32'd1);
          checkOutput("rnd_code", 32'(bus_if.out_code), 32'(m_code));
          checkOutput("rnd_src", 32'(bus_if.out_src), 32'(m_src));
          if (bus_if.out_ready) begin
            exp_cnt = exp_cnt + 16'd1;
            phase   = 0;
          end
        end
      endcase
      n++;
    end
    applyStimulus('0, 1'b1);
    checkOutput("rnd_drained", 32'(phase), 32'd0);
  endtask

  // Hard time limit so the bench always ends
  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog timeout at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Main sequence
  initial begin
    int          waited;
    logic [10:0] d;
    checks = 0;
    errors = 0;
    for (int i = 0; i < NUM_REQ; i++) word_q[i] = '0;
    applyStimulus('0, 1'b0);
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;

    vecs[0] = '{src: 0, data: 11'h001, code: 15'h0007};
    vecs[1] = '{src: 2, data: 11'h000, code: 15'h0000};
    vecs[2] = '{src: 2, data: 11'h7FF, code: 15'h7FFF};
    vecs[3] = '{src: 2, data: 11'h400, code: 15'h408B};

    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_valid", 32'(bus_if.out_valid), 32'd0);
    checkOutput("rst_code", 32'(bus_if.out_code), 32'd0);
    checkOutput("rst_src", 32'(bus_if.out_src), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_cnt", 32'(word_cnt), 32'd0);
    checkOutput("rst_enc_d", 32'(bus_if.enc_d), 32'd0);
    checkOutput("rst_ready", 32'(bus_if.req_ready), 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    last_g  = NUM_REQ - 1;
    exp_cnt = '0;

    $display("[TB] encoding vectors");
    for (int i = 0; i < 4; i++) begin
      sendWord(vecs[i].src, vecs[i].data, vecs[i].code, 0, -1);
    end

    $display("[TB] backpressure");
    d         = 11'($urandom);
    word_q[3] = 11'($urandom);
    sendWord(1, d, ham_enc(d), 10, 3);
    sendWord(3, word_q[3], ham_enc(word_q[3]), 0, -1);

    $display("[TB] fairness with all requesters asking");
    runRandom(40, 1'b1);

    $display("[TB] random traffic");
    runRandom(400, 1'b0);

    $display("[TB] reset during ENC");
    @(negedge clk);
    word_q[2] = 11'h5A5;
    applyStimulus(4'b0100, 1'b1);
    #1;
    waited = 0;
    while (bus_if.req_ready == '0 && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    checkOutput("mid_grant", 32'(bus_if.req_ready), 32'h4);
    @(posedge clk);
    #1;
    checkOutput("mid_busy", 32'(busy), 32'd1);
    #2;
    applyStimulus('0, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(bus_if.out_valid), 32'd0);
    checkOutput("mid_rst_code", 32'(bus_if.out_code), 32'd0);
    checkOutput("mid_rst_src", 32'(bus_if.out_src), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_cnt", 32'(word_cnt), 32'd0);
    checkOutput("mid_rst_enc_d", 32'(bus_if.enc_d), 32'd0);
    checkOutput("mid_rst_ready", 32'(bus_if.req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    last_g  = NUM_REQ - 1;
    exp_cnt = '0;
    applyStimulus(4'b1111, 1'b1);
    #1;
    checkOutput("post_rst_grant", 32'(bus_if.req_ready), 32'h1);
    checkOutput("post_rst_cnt", 32'(word_cnt), 32'd0);
    applyStimulus('0, 1'b1);
    runRandom(80, 1'b1);
    runRandom(100, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ham_15_11_enc_sched.md
# ham_15_11_enc_sched

Scheduler for the shared (15,11) Hamming encoder datapath. It arbitrates round-robin among NUM_REQ requesters, each supplying 11-bit data words. It sequences the winning word through a single combinational encoder instance, registers the 15-bit codeword and presents it downstream under a valid/ready handshake. It sits between the data producers and the single encoder instance, so no producer needs its own encoder.

## Interface
- NUM_REQ, default 4: number of requesters, 2..8.
- SRC_W, default 2: requester-index width, equal to clog2(NUM_REQ).
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: reset, asynchronous and active-low.
- req_valid, in, NUM_REQ: per-requester word-available flags.
- req_data, in, 11*NUM_REQ: data words. Requester i occupies bits [11i+10:11i].
- req_ready, out, NUM_REQ: one-hot grant. A handshake completes on any cycle where req_valid[i] and req_ready[i] are both high.
- enc_d, out, 11: data word driven to the encoder.
- enc_c, in, 15: codeword returned by the encoder, combinational from enc_d.
- out_valid, out, 1: codeword available.
- out_code, out, 15: registered codeword.
- out_src, out, SRC_W: index of the requester that produced out_code.
- out_ready, in, 1: downstream accepts the codeword.
- busy, out, 1: high in any state other than IDLE.
- word_cnt, out, 16: count of codewords delivered. Wraps from 16'hFFFF to 0.

## Operation
- The FSM has three states: IDLE, ENC, HOLD.
- IDLE:
  - If no requester has req_valid high, remain in IDLE with req_ready all zero.
  - Otherwise assert req_ready for exactly one requester, chosen round-robin.
  - On the next clock edge: latch the granted req_data into data_reg, latch the grant index into src_reg, set last_grant to the grant index, and go to ENC.
- ENC: enc_d = data_reg; on the clock edge, out_code <= enc_c, out_src <= src_reg, out_valid <= 1, go to HOLD.
- HOLD: out_valid is high.
  - If out_ready is high, on the clock edge out_valid <= 0, word_cnt increments, go to IDLE.
  - Otherwise hold all outputs stable.
- enc_d outputs data_reg in every state, so the encoder input does not toggle from unselected requesters.
- Round-robin rule: priority starts at index (last_grant+1) mod NUM_REQ and ascends with wrap. The granted requester becomes lowest priority for the next arbitration.
- req_ready is combinational from state, req_valid and last_grant. It is never asserted outside IDLE and never for a requester whose req_valid is low.
- A requester must hold req_valid and req_data stable until its handshake completes. The scheduler does not check this.

## Timing
- Reset (async, rst_n low) sets:
  - state = IDLE;
  - req_ready = 0, out_valid = 0, out_code = 15'h0000, out_src = 0, busy = 0, word_cnt = 0, data_reg = 0, enc_d = 0;
  - last_grant = NUM_REQ-1, so requester 0 wins the first arbitration.
- Reset while in ENC or HOLD aborts the in-flight word without delivering it, and word_cnt does not increment for it.
- Latency: a handshake at edge N gives out_valid high after edge N+1, which is the first cycle out_valid is observed.
- Minimum spacing: 3 cycles per codeword when out_ready is held high.
- Simultaneous requests are resolved by the round-robin rule only. No requester waits more than NUM_REQ arbitrations.
- out_ready high outside HOLD is ignored.
- Backpressure: an arbitrary-length stall in HOLD leaves out_code, out_src and word_cnt unchanged, and req_ready stays zero throughout.
- word_cnt wraps modulo 2^16 with no flag.

## Test plan
- Single word: requester 0 presents 11'h001 with out_ready = 1 → out_code = 15'h0007, out_src = 0, out_valid high for one cycle, word_cnt = 1.
- Encoding vectors through requester 2:
  - 11'h000 → 15'h0000;
  - 11'h7FF → 15'h7FFF;
  - 11'h400 → 15'h408B.
  - out_src = 2 for each.
- Fairness: all 4 requesters hold req_valid continuously → grant order 0,1,2,3,0,1…, never the same index twice in a row while others wait.
- Backpressure: out_ready held low for 10 cycles in HOLD → out_code and out_src stable, req_ready = 0 throughout, no word_cnt change. Releasing out_ready → delivery, then IDLE.
- Reset mid-operation: pull rst_n low during ENC → all outputs at their reset values immediately (asynchronous). After release, requester 0 wins first, and word_cnt = 0.
- Counter wrap: deliver 65536 words → word_cnt returns to 0 with no glitch on out_valid.
